// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage hazard/forwarding bundle: decoder-side inputs, register-file and
// stage results in, pipeline-register control and forwarded operands out.
interface hazard_fwd_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                    id_valid;
    logic [RA_W-1:0]         id_rs1_addr;
    logic [RA_W-1:0]         id_rs2_addr;
    logic                    id_rs1_used;
    logic                    id_rs2_used;
    logic [RA_W-1:0]         id_rd_addr;
    logic                    id_rf_wen;
    logic                    id_is_load;
    logic [XLEN-1:0]         rf_rs1_data;
    logic [XLEN-1:0]         rf_rs2_data;
    logic [DEPTH*XLEN-1:0]   stage_result;
    logic                    ex_redirect;

    logic                    stall_if;
    logic                    stall_id;
    logic                    flush_id;
    logic                    bubble_ex;
    logic [SEL_W-1:0]        rs1_fwd_sel;
    logic [SEL_W-1:0]        rs2_fwd_sel;
    logic [XLEN-1:0]         rs1_fwd_data;
    logic [XLEN-1:0]         rs2_fwd_data;
    logic [CNT_W-1:0]        stall_count;
    logic [CNT_W-1:0]        flush_count;
    logic [CNT_W-1:0]        retire_count;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, rf_rs1_data, rf_rs2_data,
               stage_result, ex_redirect,
        input  stall_if, stall_id, flush_id, bubble_ex, rs1_fwd_sel, rs2_fwd_sel,
               rs1_fwd_data, rs2_fwd_data, stall_count, flush_count, retire_count
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_wen, id_is_load, rf_rs1_data, rf_rs2_data,
               stage_result, ex_redirect,
        output stall_if, stall_id, flush_id, bubble_ex, rs1_fwd_sel, rs2_fwd_sel,
               rs1_fwd_data, rs2_fwd_data, stall_count, flush_count, retire_count
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: shadow scoreboard of in-flight writers
// (slot0=EX .. slot DEPTH-1=WB), operand forward selects, load-use stalls and flushes.
module hazard_fwd_ctrl #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int DEPTH    = 3,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    hazard_fwd_ctrl_if.slave  bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            wen;
        logic            is_load;
    } slot_t;

    slot_t            slots [DEPTH];
    slot_t            issue;

    logic             rs1_hit, rs1_rdy, rs2_hit, rs2_rdy;
    int               rs1_idx, rs2_idx;
    logic             rs1_haz, rs2_haz, hazard;
    logic [SEL_W-1:0] rs1_sel, rs2_sel;
    logic [XLEN-1:0]  rs1_data, rs2_data;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, retire_cnt;

    function automatic logic slot_match(input slot_t s, input logic used,
                                        input logic [RA_W-1:0] addr);
        return used && s.valid && s.wen && (s.rd == addr) && (addr != '0);
    endfunction

    function automatic logic slot_ready(input slot_t s, input int idx);
        return !s.is_load || (idx >= LOAD_LAT);
    endfunction

    // Scan oldest to youngest so the youngest matching slot overrides.
    always_comb begin
        rs1_hit = 1'b0;
        rs1_rdy = 1'b0;
        rs1_idx = 0;
        rs2_hit = 1'b0;
        rs2_rdy = 1'b0;
        rs2_idx = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_match(slots[i], bus.id_rs1_used, bus.id_rs1_addr)) begin
                rs1_hit = 1'b1;
                rs1_rdy = slot_ready(slots[i], i);
                rs1_idx = i;
            end
            if (slot_match(slots[i], bus.id_rs2_used, bus.id_rs2_addr)) begin
                rs2_hit = 1'b1;
                rs2_rdy = slot_ready(slots[i], i);
                rs2_idx = i;
            end
        end
    end

    always_comb begin
        rs1_sel  = '0;
        rs2_sel  = '0;
        rs1_data = bus.rf_rs1_data;
        rs2_data = bus.rf_rs2_data;
        if (FWD_EN != 0) begin
            rs1_haz = rs1_hit && !rs1_rdy;
            rs2_haz = rs2_hit && !rs2_rdy;
            if (rs1_hit && rs1_rdy) begin
                rs1_sel  = SEL_W'(rs1_idx + 1);
                rs1_data = bus.stage_result[rs1_idx*XLEN +: XLEN];
            end
            if (rs2_hit && rs2_rdy) begin
                rs2_sel  = SEL_W'(rs2_idx + 1);
                rs2_data = bus.stage_result[rs2_idx*XLEN +: XLEN];
            end
        end else begin
            // No write-through from WB: even a slot DEPTH-1 match must wait.
            rs1_haz = rs1_hit;
            rs2_haz = rs2_hit;
        end
    end

    // A redirect kills the ID instruction, so it never also stalls.
    assign hazard = bus.id_valid && (rs1_haz || rs2_haz) && !bus.ex_redirect;

    always_comb begin
        issue = '0;
        if (bus.id_valid && !hazard && !bus.ex_redirect) begin
            issue.valid   = 1'b1;
            issue.rd      = bus.id_rd_addr;
            issue.wen     = bus.id_rf_wen;
            issue.is_load = bus.id_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            slots[0] <= issue;
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bus.ex_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (slots[DEPTH-1].valid && (retire_cnt != '1)) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

    assign bus.stall_if     = hazard;
    assign bus.stall_id     = hazard;
    assign bus.flush_id     = bus.ex_redirect;
    assign bus.bubble_ex    = hazard || bus.ex_redirect;
    assign bus.rs1_fwd_sel  = rs1_sel;
    assign bus.rs2_fwd_sel  = rs2_sel;
    assign bus.rs1_fwd_data = rs1_data;
    assign bus.rs2_fwd_data = rs2_data;
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;
    assign bus.retire_count = retire_cnt;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor
// compares them against a forwarding DUT (a) and a stall-only DUT (b).
module tb_hazard_fwd_ctrl;
    localparam logic [31:0] R1 = 32'hAAAA_0001;
    localparam logic [31:0] R2 = 32'hAAAA_0002;
    localparam logic [31:0] S0 = 32'h0000_1234;
    localparam logic [31:0] S1 = 32'hBBBB_0001;
    localparam logic [31:0] S2 = 32'hCCCC_0002;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.XLEN(32), .RA_W(5), .DEPTH(3), .CNT_W(32)) ifa ();
    hazard_fwd_ctrl_if #(.XLEN(32), .RA_W(5), .DEPTH(3), .CNT_W(32)) ifb ();

    hazard_fwd_ctrl #(.FWD_EN(1), .LOAD_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    hazard_fwd_ctrl #(.FWD_EN(0), .LOAD_LAT(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        int          step;
        bit          on_b;
        bit          chk_cnt;
        logic        stall;
        logic        flush;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] rc;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input int step, input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL step%0d %s: got 0x%0h expected 0x%0h", step, nm, act, req);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.on_b) begin
                    chk(e.step, "b.stall_if", 32'(ifb.stall_if), 32'(e.stall));
                    chk(e.step, "b.stall_id", 32'(ifb.stall_id), 32'(e.stall));
                    chk(e.step, "b.flush_id", 32'(ifb.flush_id), 32'(e.flush));
                    chk(e.step, "b.bubble_ex", 32'(ifb.bubble_ex), 32'(e.stall | e.flush));
                    chk(e.step, "b.rs1_sel", 32'(ifb.rs1_fwd_sel), 32'(e.sel1));
                    chk(e.step, "b.rs2_sel", 32'(ifb.rs2_fwd_sel), 32'(e.sel2));
                    chk(e.step, "b.rs1_data", ifb.rs1_fwd_data, e.d1);
                    chk(e.step, "b.rs2_data", ifb.rs2_fwd_data, e.d2);
                    if (e.chk_cnt) begin
                        chk(e.step, "b.stall_count", ifb.stall_count, e.sc);
                        chk(e.step, "b.flush_count", ifb.flush_count, e.fc);
                        chk(e.step, "b.retire_count", ifb.retire_count, e.rc);
                    end
                end else begin
                    chk(e.step, "a.stall_if", 32'(ifa.stall_if), 32'(e.stall));
                    chk(e.step, "a.stall_id", 32'(ifa.stall_id), 32'(e.stall));
                    chk(e.step, "a.flush_id", 32'(ifa.flush_id), 32'(e.flush));
                    chk(e.step, "a.bubble_ex", 32'(ifa.bubble_ex), 32'(e.stall | e.flush));
                    chk(e.step, "a.rs1_sel", 32'(ifa.rs1_fwd_sel), 32'(e.sel1));
                    chk(e.step, "a.rs2_sel", 32'(ifa.rs2_fwd_sel), 32'(e.sel2));
                    chk(e.step, "a.rs1_data", ifa.rs1_fwd_data, e.d1);
                    chk(e.step, "a.rs2_data", ifa.rs2_fwd_data, e.d2);
                    if (e.chk_cnt) begin
                        chk(e.step, "a.stall_count", ifa.stall_count, e.sc);
                        chk(e.step, "a.flush_count", ifa.flush_count, e.fc);
                        chk(e.step, "a.retire_count", ifa.retire_count, e.rc);
                    end
                end
            end
        end
    end

    task automatic drive(input bit on_b, input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                         input logic w, input logic ld, input logic rdr);
        if (on_b) begin
            ifb.id_valid = v;  ifb.id_rs1_addr = r1; ifb.id_rs1_used = u1;
            ifb.id_rs2_addr = r2; ifb.id_rs2_used = u2; ifb.id_rd_addr = rd;
            ifb.id_rf_wen = w; ifb.id_is_load = ld; ifb.ex_redirect = rdr;
        end else begin
            ifa.id_valid = v;  ifa.id_rs1_addr = r1; ifa.id_rs1_used = u1;
            ifa.id_rs2_addr = r2; ifa.id_rs2_used = u2; ifa.id_rd_addr = rd;
            ifa.id_rf_wen = w; ifa.id_is_load = ld; ifa.ex_redirect = rdr;
        end
    endtask

    task automatic expect_out(input int step, input bit on_b, input logic st, input logic fl,
                              input logic [1:0] s1, input logic [1:0] s2,
                              input logic [31:0] d1, input logic [31:0] d2, input bit cc,
                              input logic [31:0] sc, input logic [31:0] fc, input logic [31:0] rc);
        exp_t e;
        e.step = step; e.on_b = on_b; e.chk_cnt = cc; e.stall = st; e.flush = fl;
        e.sel1 = s1; e.sel2 = s2; e.d1 = d1; e.d2 = d2; e.sc = sc; e.fc = fc; e.rc = rc;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now();
        #1;
        -> chk_ev;
        #1;
    endtask

    // One pipeline cycle: present ID inputs, queue expectation, advance.
    task automatic cyc(input int step, input bit on_b, input logic v,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic w, input logic ld, input logic rdr,
                       input logic st, input logic fl, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] sc, input logic [31:0] fc, input logic [31:0] rc);
        drive(on_b, v, r1, u1, r2, u2, rd, w, ld, rdr);
        expect_out(step, on_b, st, fl, s1, s2, d1, d2, 1'b1, sc, fc, rc);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        ifa.rf_rs1_data = R1; ifa.rf_rs2_data = R2; ifa.stage_result = {S2, S1, S0};
        ifb.rf_rs1_data = R1; ifb.rf_rs2_data = R2; ifb.stage_result = {S2, S1, S0};
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        expect_out(0, 1'b0, 0, 0, 0, 0, R1, R2, 1'b1, 0, 0, 0);
        expect_out(0, 1'b1, 0, 0, 0, 0, R1, R2, 1'b1, 0, 0, 0);
        check_now();
        tick();
        reset = 1'b1;

        // Forwarding DUT: ALU forward, x0, load-use, redirect, slot priority.
        //   step b  v  r1 u1 r2 u2 rd w  ld rd  st fl s1 s2 d1  d2  sc fc rc
        cyc(1,  0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(2,  0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, S0, R2, 0, 0, 0);
        cyc(3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(4,  0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(5,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 1);
        cyc(6,  0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, R1, R2, 0, 0, 2);
        cyc(7,  0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 1, 0, 0, 0, R1, R2, 0, 0, 2);
        cyc(8,  0, 1, 0, 0, 7, 1, 8, 1, 0, 0, 0, 0, 0, 2, R1, S1, 1, 0, 3);
        cyc(9,  0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, R1, R2, 1, 0, 4);
        cyc(10, 0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, R1, R2, 1, 0, 5);
        cyc(11, 0, 1, 8, 1, 9, 1, 0, 0, 0, 0, 0, 0, 3, 2, S2, S1, 1, 1, 5);
        cyc(12, 0, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, R1, R2, 1, 1, 6);

        // Load-use stall, then asynchronous reset in the middle of it.
        drive(1'b0, 1, 10, 1, 0, 0, 0, 0, 0, 0);
        expect_out(13, 1'b0, 1, 0, 0, 0, R1, R2, 1'b1, 1, 1, 7);
        @(negedge clk);
        #1;
        reset = 1'b0;
        expect_out(14, 1'b0, 0, 0, 0, 0, R1, R2, 1'b1, 0, 0, 0);
        check_now();
        tick();
        expect_out(15, 1'b0, 0, 0, 0, 0, R1, R2, 1'b1, 0, 0, 0);
        tick();
        reset = 1'b1;
        cyc(16, 0, 1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(17, 0, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(18, 0, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(19, 0, 1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 1);
        cyc(21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 2);
        cyc(22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 3);
        cyc(23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 4);

        // Stall-only DUT: RAW on x3 waits out EX, MEM and WB.
        cyc(30, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(31, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, R1, R2, 0, 0, 0);
        cyc(32, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, R1, R2, 1, 0, 0);
        cyc(33, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, R1, R2, 2, 0, 0);
        cyc(34, 1, 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, R1, R2, 3, 0, 1);
        cyc(35, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, R1, R2, 3, 0, 1);
        cyc(36, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R1, R2, 4, 0, 1);

        @(negedge clk);
        #1;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
